// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared constants, state codes and types for the fetch sequencer
package pc_fetch_unit_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic        redirect;
        logic [31:0] target;
    } redirect_t;

    // Jump keeps the top nibble of the decode-stage PC+4 (MIPS-style region jump).
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory handshake and fetch-result bundle
interface pc_fetch_unit_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        FetchValid;
    logic [31:0] FetchPC;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        output FetchValid,
        output FetchPC
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        input  FetchValid,
        input  FetchPC
    );

endinterface

// File: rtl/pc_fetch_unit_next_pc_select.sv
// rtl/pc_fetch_unit_next_pc_select.sv - combinational redirect target mux (jump beats branch)
module next_pc_select
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] AlignedOffset,
    input  logic [31:0] DecodePCPlus4,
    input  logic        BranchTaken,
    input  logic        JumpEn,
    input  logic [25:0] JumpIndex,
    output redirect_t   sel_o
);

    logic [31:0] branch_target;
    logic [31:0] jmp_target;

    assign branch_target = DecodePCPlus4 + AlignedOffset;
    assign jmp_target    = jump_target(DecodePCPlus4, JumpIndex);

    always_comb begin
        sel_o.redirect = BranchTaken | JumpEn;
        sel_o.target   = JumpEn ? jmp_target : branch_target;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, pending-redirect latch and IDLE/REQ/HOLD fetch FSM
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        AlignedOffset,
    input  logic [31:0]        DecodePCPlus4,
    input  logic               BranchTaken,
    input  logic               JumpEn,
    input  logic [25:0]        JumpIndex,
    input  logic               Stall,
    pc_fetch_unit_if.master    imem
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;

    redirect_t   sel;

    next_pc_select u_next_pc_select (
        .AlignedOffset (AlignedOffset),
        .DecodePCPlus4 (DecodePCPlus4),
        .BranchTaken   (BranchTaken),
        .JumpEn        (JumpEn),
        .JumpIndex     (JumpIndex),
        .sel_o         (sel)
    );

    assign imem.ImemReq    = (state_q == ST_REQ);
    assign imem.ImemAddr   = pc_q;
    assign imem.FetchValid = fetch_valid_q;
    assign imem.FetchPC    = fetch_pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (sel.redirect) begin
                    pc_d = sel.target;
                end
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!imem.ImemReady) begin
                    // Address must stay put until memory answers; park the newest redirect.
                    if (sel.redirect) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = sel.target;
                    end
                end else begin
                    if (sel.redirect || pend_valid_q) begin
                        pc_d = sel.redirect ? sel.target : pend_target_q;
                    end else begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        pc_d          = pc_q + 32'(WORD_BYTES);
                    end
                    pend_valid_d  = 1'b0;
                    state_d       = Stall ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (sel.redirect) begin
                    pc_d = sel.target;
                end
                if (!Stall) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a reference model
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] AlignedOffset;
    logic [31:0] DecodePCPlus4;
    logic        BranchTaken;
    logic        JumpEn;
    logic [25:0] JumpIndex;
    logic        Stall;

    pc_fetch_unit_if imem_bus ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .AlignedOffset (AlignedOffset),
        .DecodePCPlus4 (DecodePCPlus4),
        .BranchTaken   (BranchTaken),
        .JumpEn        (JumpEn),
        .JumpIndex     (JumpIndex),
        .Stall         (Stall),
        .imem          (imem_bus.master)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum int { M_IDLE, M_WAITING, M_PARKED } mphase_t;
    mphase_t     m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_parked_target [$];
    logic        m_fv;
    logic [31:0] m_fpc;
    logic [31:0] last_fv_pc;
    logic        last_fv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] redirect_dest();
        if (JumpEn)
            return (DecodePCPlus4 & 32'hF000_0000) | (32'(JumpIndex) * 4);
        return DecodePCPlus4 + AlignedOffset;
    endfunction

    task automatic model_step();
        logic want;
        logic [31:0] dest;
        want = BranchTaken | JumpEn;
        dest = redirect_dest();
        if (reset) begin
            m_phase = M_IDLE;
            m_pc    = 32'h0;
            m_parked_target.delete();
            m_fv    = 1'b0;
            m_fpc   = 32'h0;
            return;
        end
        m_fv = 1'b0;
        if (m_phase == M_IDLE) begin
            if (want) m_pc = dest;
            m_phase = M_WAITING;
        end else if (m_phase == M_WAITING) begin
            if (!imem_bus.ImemReady) begin
                if (want) begin
                    m_parked_target.delete();
                    m_parked_target.push_back(dest);
                end
            end else begin
                if (want) m_pc = dest;
                else if (m_parked_target.size() != 0) m_pc = m_parked_target[0];
                else begin
                    m_fv  = 1'b1;
                    m_fpc = m_pc;
                    m_pc  = m_pc + 4;
                end
                m_parked_target.delete();
                m_phase = Stall ? M_PARKED : M_WAITING;
            end
        end else begin
            if (want) m_pc = dest;
            if (!Stall) m_phase = M_WAITING;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ImemReq", 32'(imem_bus.ImemReq), 32'(m_phase == M_WAITING));
        chk("ImemAddr", imem_bus.ImemAddr, m_pc);
        chk("FetchValid", 32'(imem_bus.FetchValid), 32'(m_fv));
        chk("FetchPC", imem_bus.FetchPC, m_fpc);
        if (imem_bus.FetchValid && last_fv)
            chk("FetchValid_repeat_pc", 32'(imem_bus.FetchPC != last_fv_pc), 32'd1);
        last_fv    = imem_bus.FetchValid;
        last_fv_pc = imem_bus.FetchPC;
    endtask

    task automatic quiet_inputs();
        BranchTaken   = 1'b0;
        JumpEn        = 1'b0;
        AlignedOffset = 32'h0;
        DecodePCPlus4 = 32'h0;
        JumpIndex     = 26'h0;
    endtask

    initial begin
        reset = 1'b1;
        Stall = 1'b0;
        imem_bus.ImemReady = 1'b0;
        quiet_inputs();
        last_fv    = 1'b0;
        last_fv_pc = 32'h0;
        m_phase = M_IDLE;
        m_pc    = 32'h0;
        m_fv    = 1'b0;
        m_fpc   = 32'h0;

        tick();
        chk("reset_req", 32'(imem_bus.ImemReq), 32'd0);
        chk("reset_fv", 32'(imem_bus.FetchValid), 32'd0);
        chk("reset_fpc", imem_bus.FetchPC, 32'h0);

        // Sequential fetch from reset.
        reset = 1'b0;
        imem_bus.ImemReady = 1'b1;
        tick();
        chk("first_req_addr", imem_bus.ImemAddr, 32'h0);
        tick(); chk("seq_fpc0", imem_bus.FetchPC, 32'h0);
        tick(); chk("seq_fpc4", imem_bus.FetchPC, 32'h4);
        tick(); chk("seq_fpc8", imem_bus.FetchPC, 32'h8);
        tick(); chk("pc_at_0x10", imem_bus.ImemAddr, 32'h10);

        // Backward branch while memory answers: fetch discarded.
        DecodePCPlus4 = 32'h0000_000C;
        AlignedOffset = 32'hFFFF_FFF8;
        BranchTaken   = 1'b1;
        tick();
        chk("branch_fv", 32'(imem_bus.FetchValid), 32'd0);
        chk("branch_addr", imem_bus.ImemAddr, 32'h4);

        // Jump beats a simultaneous branch.
        DecodePCPlus4 = 32'h4000_0010;
        JumpIndex     = 26'h0000100;
        JumpEn        = 1'b1;
        tick();
        chk("jump_prio_addr", imem_bus.ImemAddr, 32'h4000_0400);
        quiet_inputs();

        // Redirects during a long wait: newest one wins, address frozen.
        imem_bus.ImemReady = 1'b0;
        DecodePCPlus4 = 32'h40; AlignedOffset = 32'h40; BranchTaken = 1'b1;
        tick();
        chk("wait1_addr", imem_bus.ImemAddr, 32'h4000_0400);
        quiet_inputs();
        JumpIndex = 26'h80; JumpEn = 1'b1;
        tick();
        chk("wait2_addr", imem_bus.ImemAddr, 32'h4000_0400);
        quiet_inputs();
        tick();
        chk("wait3_addr", imem_bus.ImemAddr, 32'h4000_0400);
        imem_bus.ImemReady = 1'b1;
        tick();
        chk("pending_fv", 32'(imem_bus.FetchValid), 32'd0);
        chk("pending_addr", imem_bus.ImemAddr, 32'h200);

        // Stall on the accepting edge parks in HOLD.
        Stall = 1'b1;
        tick();
        chk("stall_fv", 32'(imem_bus.FetchValid), 32'd1);
        chk("stall_fpc", imem_bus.FetchPC, 32'h200);
        chk("hold_req", 32'(imem_bus.ImemReq), 32'd0);
        tick();
        chk("hold_req2", 32'(imem_bus.ImemReq), 32'd0);
        chk("hold_addr", imem_bus.ImemAddr, 32'h204);
        Stall = 1'b0;
        tick();
        chk("resume_req", 32'(imem_bus.ImemReq), 32'd1);

        // Reset mid-request with a redirect parked and ImemReady high.
        imem_bus.ImemReady = 1'b0;
        DecodePCPlus4 = 32'h100; AlignedOffset = 32'h0; BranchTaken = 1'b1;
        tick();
        quiet_inputs();
        imem_bus.ImemReady = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst_mid_addr", imem_bus.ImemAddr, 32'h0);
        chk("rst_mid_fv", 32'(imem_bus.FetchValid), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_pending_cleared_fv", 32'(imem_bus.FetchValid), 32'd1);
        chk("rst_pending_cleared_fpc", imem_bus.FetchPC, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 199) == 0);
            imem_bus.ImemReady = ($urandom_range(0, 9) < 6);
            Stall              = ($urandom_range(0, 3) == 0);
            BranchTaken        = ($urandom_range(0, 6) == 0);
            JumpEn             = ($urandom_range(0, 11) == 0);
            AlignedOffset      = $urandom & 32'hFFFF_FFFC;
            DecodePCPlus4      = $urandom & 32'hFFFF_FFFC;
            JumpIndex          = 26'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
